// File: rtl/ahb_mem_arbiter.sv
// Two-master to one-slave AHB-Lite arbiter for a shared memory.
// A master that loses arbitration is parked in a one-deep pending register and replayed on a later grant.
module ahb_mem_arbiter #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS_M0,
  input  logic [31:0] HADDR_M0,
  input  logic        HWRITE_M0,
  input  logic [2:0]  HSIZE_M0,
  input  logic [31:0] HWDATA_M0,
  output logic        HREADY_M0,
  output logic [31:0] HRDATA_M0,
  output logic        HRESP_M0,
  input  logic [1:0]  HTRANS_M1,
  input  logic [31:0] HADDR_M1,
  input  logic        HWRITE_M1,
  input  logic [2:0]  HSIZE_M1,
  input  logic [31:0] HWDATA_M1,
  output logic        HREADY_M1,
  output logic [31:0] HRDATA_M1,
  output logic        HRESP_M1,
  output logic        HSEL_S,
  output logic [31:0] HADDR_S,
  output logic [1:0]  HTRANS_S,
  output logic        HWRITE_S,
  output logic [2:0]  HSIZE_S,
  output logic [31:0] HWDATA_S,
  output logic        HREADY_S,
  input  logic        HREADYOUT_S,
  input  logic [31:0] HRDATA_S
);

  localparam bit FIXED_PRIO = (PRIORITY_MODE != 0);

  logic        pend_0, pend_1;
  logic [31:0] paddr_0, paddr_1;
  logic        pwrite_0, pwrite_1;
  logic [2:0]  psize_0, psize_1;
  logic        data_valid;
  logic        data_owner;   // 0 = M0, 1 = M1
  logic        last_grant;   // 0 = M0, 1 = M1
  logic        live_0, live_1;
  logic        req_0, req_1;
  logic        grant_0, grant_1, issue;

  // A master is stalled while parked, or while its own data phase is being held by the slave.
  assign HREADY_M0 = ~(pend_0 | (data_valid & ~data_owner & ~HREADYOUT_S));
  assign HREADY_M1 = ~(pend_1 | (data_valid &  data_owner & ~HREADYOUT_S));

  // Only NONSEQ/SEQ count; IDLE and BUSY are never forwarded or captured.
  assign live_0 = (HTRANS_M0 inside {2'b10, 2'b11}) & HREADY_M0;
  assign live_1 = (HTRANS_M1 inside {2'b10, 2'b11}) & HREADY_M1;
  assign req_0  = pend_0 | live_0;
  assign req_1  = pend_1 | live_1;

  // Reset gates the grant so nothing reaches the slave while HRESET is high.
  assign grant_0 = ~HRESET & HREADYOUT_S & req_0 & (~req_1 | FIXED_PRIO | last_grant);
  assign grant_1 = ~HRESET & HREADYOUT_S & req_1 & ~grant_0;
  assign issue   = grant_0 | grant_1;

  always_comb begin
    HSEL_S   = 1'b0;
    HTRANS_S = 2'b00;
    HADDR_S  = HADDR_M0;
    HWRITE_S = HWRITE_M0;
    HSIZE_S  = HSIZE_M0;
    if (grant_0) begin
      HSEL_S   = 1'b1;
      HTRANS_S = 2'b10;
      if (pend_0) begin
        HADDR_S  = paddr_0;
        HWRITE_S = pwrite_0;
        HSIZE_S  = psize_0;
      end
    end else if (grant_1) begin
      HSEL_S   = 1'b1;
      HTRANS_S = 2'b10;
      if (pend_1) begin
        HADDR_S  = paddr_1;
        HWRITE_S = pwrite_1;
        HSIZE_S  = psize_1;
      end else begin
        HADDR_S  = HADDR_M1;
        HWRITE_S = HWRITE_M1;
        HSIZE_S  = HSIZE_M1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_0     <= 1'b0;
      pend_1     <= 1'b0;
      paddr_0    <= '0;
      paddr_1    <= '0;
      pwrite_0   <= 1'b0;
      pwrite_1   <= 1'b0;
      psize_0    <= '0;
      psize_1    <= '0;
      data_valid <= 1'b0;
      data_owner <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (issue) last_grant <= grant_1;

      if (grant_0 && pend_0) begin
        pend_0 <= 1'b0;
      end else if (live_0 && !grant_0) begin
        pend_0   <= 1'b1;
        paddr_0  <= HADDR_M0;
        pwrite_0 <= HWRITE_M0;
        psize_0  <= HSIZE_M0;
      end

      if (grant_1 && pend_1) begin
        pend_1 <= 1'b0;
      end else if (live_1 && !grant_1) begin
        pend_1   <= 1'b1;
        paddr_1  <= HADDR_M1;
        pwrite_1 <= HWRITE_M1;
        psize_1  <= HSIZE_M1;
      end

      if (HREADYOUT_S) begin
        data_owner <= grant_1;
        data_valid <= issue;
      end
    end
  end

  assign HWDATA_S  = data_owner ? HWDATA_M1 : HWDATA_M0;
  assign HRDATA_M0 = HRDATA_S;
  assign HRDATA_M1 = HRDATA_S;
  assign HRESP_M0  = 1'b0;
  assign HRESP_M1  = 1'b0;
  assign HREADY_S  = HREADYOUT_S;

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Bench for ahb_mem_arbiter: one round-robin and one fixed-priority instance share the same stimulus.
module tb_ahb_mem_arbiter;

  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HRESET;
  logic [1:0]  htrans [2];
  logic [31:0] haddr  [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [31:0] hwdata [2];
  logic        hreadyout_s;
  logic [31:0] hrdata_s;

  // Index g: 0 = round-robin instance, 1 = fixed-priority instance.
  logic        hready_m0 [2];
  logic        hready_m1 [2];
  logic [31:0] hrdata_m0 [2];
  logic [31:0] hrdata_m1 [2];
  logic        hresp_m0  [2];
  logic        hresp_m1  [2];
  logic        hsel_s    [2];
  logic [31:0] haddr_s   [2];
  logic [1:0]  htrans_s  [2];
  logic        hwrite_s  [2];
  logic [2:0]  hsize_s   [2];
  logic [31:0] hwdata_s  [2];
  logic        hready_s  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ahb_mem_arbiter #(.PRIORITY_MODE(g)) u_dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .HTRANS_M0(htrans[0]), .HADDR_M0(haddr[0]), .HWRITE_M0(hwrite[0]),
      .HSIZE_M0(hsize[0]), .HWDATA_M0(hwdata[0]),
      .HREADY_M0(hready_m0[g]), .HRDATA_M0(hrdata_m0[g]), .HRESP_M0(hresp_m0[g]),
      .HTRANS_M1(htrans[1]), .HADDR_M1(haddr[1]), .HWRITE_M1(hwrite[1]),
      .HSIZE_M1(hsize[1]), .HWDATA_M1(hwdata[1]),
      .HREADY_M1(hready_m1[g]), .HRDATA_M1(hrdata_m1[g]), .HRESP_M1(hresp_m1[g]),
      .HSEL_S(hsel_s[g]), .HADDR_S(haddr_s[g]), .HTRANS_S(htrans_s[g]),
      .HWRITE_S(hwrite_s[g]), .HSIZE_S(hsize_s[g]), .HWDATA_S(hwdata_s[g]),
      .HREADY_S(hready_s[g]), .HREADYOUT_S(hreadyout_s), .HRDATA_S(hrdata_s)
    );
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic idle_masters();
    for (int x = 0; x < 2; x++) begin
      htrans[x] = 2'b00;
      haddr[x]  = '0;
      hwrite[x] = 1'b0;
      hsize[x]  = 3'd2;
      hwdata[x] = '0;
    end
    hreadyout_s = 1'b1;
    hrdata_s    = '0;
  endtask

  task automatic random_inputs();
    for (int x = 0; x < 2; x++) begin
      htrans[x] = 2'($urandom_range(0, 3));
      haddr[x]  = $urandom;
      hwrite[x] = 1'($urandom_range(0, 1));
      hsize[x]  = 3'($urandom_range(0, 2));
      hwdata[x] = $urandom;
    end
    hreadyout_s = ($urandom_range(0, 3) != 0);
    hrdata_s    = $urandom;
  endtask

  // Leaves the caller at a falling edge, reset released, masters idle.
  task automatic do_reset();
    @(negedge HCLK);
    HRESET = 1'b1;
    idle_masters();
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge HCLK);
    HRESET = 1'b1;
    random_inputs();
    @(negedge HCLK);
    random_inputs();
    #1;
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if (hsel_s[g] !== 1'b0 || htrans_s[g] !== 2'b00) $display("FAIL reset_idle g%0d: got sel=%b trans=%b want sel=0 trans=00", g, hsel_s[g], htrans_s[g]);
      else n_pass++;
      n_checks++;
      if (hready_m0[g] !== 1'b1 || hready_m1[g] !== 1'b1) $display("FAIL reset_hready g%0d: got %b%b want 11", g, hready_m0[g], hready_m1[g]);
      else n_pass++;
    end
    @(negedge HCLK);
    HRESET = 1'b0;
    idle_masters();
    #1;
    for (int g = 0; g < 2; g++) begin
      n_checks++;
      if (hsel_s[g] !== 1'b0 || htrans_s[g] !== 2'b00 || hready_m0[g] !== 1'b1 || hready_m1[g] !== 1'b1 ||
          hresp_m0[g] !== 1'b0 || hresp_m1[g] !== 1'b0)
        $display("FAIL post_reset g%0d: got sel=%b trans=%b rdy=%b%b resp=%b%b want 0 00 11 00", g,
                 hsel_s[g], htrans_s[g], hready_m0[g], hready_m1[g], hresp_m0[g], hresp_m1[g]);
      else n_pass++;
    end
  endtask

  task automatic test_single_write();
    do_reset();
    htrans[0] = 2'b10; haddr[0] = 32'h10; hwrite[0] = 1'b1; hsize[0] = 3'd2;
    #1;
    n_checks++;
    if (hsel_s[0] !== 1'b1 || htrans_s[0] !== 2'b10 || haddr_s[0] !== 32'h10 || hwrite_s[0] !== 1'b1)
      $display("FAIL single_addr: got sel=%b trans=%b addr=%h wr=%b want 1 10 00000010 1", hsel_s[0], htrans_s[0], haddr_s[0], hwrite_s[0]);
    else n_pass++;
    n_checks++;
    if (hready_m0[0] !== 1'b1) $display("FAIL single_rdy_t: got %b want 1", hready_m0[0]);
    else n_pass++;
    @(negedge HCLK);
    htrans[0] = 2'b00; hwdata[0] = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (hwdata_s[0] !== 32'hDEADBEEF || hsel_s[0] !== 1'b0)
      $display("FAIL single_data: got wdata=%h sel=%b want deadbeef 0", hwdata_s[0], hsel_s[0]);
    else n_pass++;
    n_checks++;
    if (hready_m0[0] !== 1'b1) $display("FAIL single_rdy_t1: got %b want 1", hready_m0[0]);
    else n_pass++;
  endtask

  task automatic test_contention();
    do_reset();
    htrans[0] = 2'b10; haddr[0] = 32'h20; hwrite[0] = 1'b0;
    htrans[1] = 2'b10; haddr[1] = 32'h30; hwrite[1] = 1'b1;
    #1;
    n_checks++;
    if (hsel_s[0] !== 1'b1 || haddr_s[0] !== 32'h20 || hwrite_s[0] !== 1'b0)
      $display("FAIL cont_t: got sel=%b addr=%h wr=%b want 1 00000020 0", hsel_s[0], haddr_s[0], hwrite_s[0]);
    else n_pass++;
    @(negedge HCLK);
    htrans[0] = 2'b00; haddr[0] = '0;
    hwdata[1] = 32'hA5A5A5A5;
    #1;
    n_checks++;
    if (hsel_s[0] !== 1'b1 || haddr_s[0] !== 32'h30 || hwrite_s[0] !== 1'b1)
      $display("FAIL cont_t1: got sel=%b addr=%h wr=%b want 1 00000030 1", hsel_s[0], haddr_s[0], hwrite_s[0]);
    else n_pass++;
    n_checks++;
    if (hready_m1[0] !== 1'b0) $display("FAIL cont_rdy_t1: got %b want 0", hready_m1[0]);
    else n_pass++;
    @(negedge HCLK);
    htrans[1] = 2'b00;
    #1;
    n_checks++;
    if (hready_m1[0] !== 1'b1 || hwdata_s[0] !== 32'hA5A5A5A5 || hsel_s[0] !== 1'b0)
      $display("FAIL cont_t2: got rdy1=%b wdata=%h sel=%b want 1 a5a5a5a5 0", hready_m1[0], hwdata_s[0], hsel_s[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    htrans[0] = 2'b10; haddr[0] = 32'h100;
    htrans[1] = 2'b10; haddr[1] = 32'h200;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++;
      if (hsel_s[0] !== 1'b1 || haddr_s[0] !== ((i % 2 == 0) ? 32'h100 : 32'h200))
        $display("FAIL rr_grant%0d: got sel=%b addr=%h want 1 %h", i, hsel_s[0], haddr_s[0], (i % 2 == 0) ? 32'h100 : 32'h200);
      else n_pass++;
      n_checks++;
      if (hsel_s[1] !== 1'b1 || haddr_s[1] !== 32'h100)
        $display("FAIL fixed_grant%0d: got sel=%b addr=%h want 1 00000100", i, hsel_s[1], haddr_s[1]);
      else n_pass++;
      @(negedge HCLK);
    end
    idle_masters();
  endtask

  task automatic test_stall();
    do_reset();
    htrans[0] = 2'b10; haddr[0] = 32'h50; hwrite[0] = 1'b1;
    #1;
    n_checks++;
    if (hsel_s[0] !== 1'b1 || haddr_s[0] !== 32'h50)
      $display("FAIL stall_issue: got sel=%b addr=%h want 1 00000050", hsel_s[0], haddr_s[0]);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      htrans[0] = 2'b00;
      hreadyout_s = 1'b0;
      htrans[1] = 2'b10; haddr[1] = 32'h40;
      #1;
      n_checks++;
      if (hready_m0[0] !== 1'b0 || hsel_s[0] !== 1'b0 || htrans_s[0] !== 2'b00 || haddr_s[0] !== 32'h50)
        $display("FAIL stall_k%0d: got rdy0=%b sel=%b trans=%b addr=%h want 0 0 00 00000050", k, hready_m0[0], hsel_s[0], htrans_s[0], haddr_s[0]);
      else n_pass++;
      n_checks++;
      if (hready_m1[0] !== (k == 0)) $display("FAIL stall_rdy1_k%0d: got %b want %b", k, hready_m1[0], (k == 0));
      else n_pass++;
    end
    @(negedge HCLK);
    hreadyout_s = 1'b1;
    #1;
    n_checks++;
    if (hsel_s[0] !== 1'b1 || haddr_s[0] !== 32'h40 || hready_m0[0] !== 1'b1)
      $display("FAIL stall_release: got sel=%b addr=%h rdy0=%b want 1 00000040 1", hsel_s[0], haddr_s[0], hready_m0[0]);
    else n_pass++;
    @(negedge HCLK);
    idle_masters();
  endtask

  task automatic test_reset_pending();
    do_reset();
    htrans[0] = 2'b10; haddr[0] = 32'h20;
    htrans[1] = 2'b10; haddr[1] = 32'h40; hwrite[1] = 1'b1;
    #1;
    n_checks++;
    if (hsel_s[0] !== 1'b1 || haddr_s[0] !== 32'h20)
      $display("FAIL rstp_t: got sel=%b addr=%h want 1 00000020", hsel_s[0], haddr_s[0]);
    else n_pass++;
    @(negedge HCLK);
    HRESET = 1'b1;
    idle_masters();
    #1;
    n_checks++;
    if (hsel_s[0] !== 1'b0) $display("FAIL rstp_during: got sel=%b addr=%h want sel 0", hsel_s[0], haddr_s[0]);
    else n_pass++;
    @(negedge HCLK);
    HRESET = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++;
      if (hsel_s[0] !== 1'b0 || hready_m1[0] !== 1'b1 || hready_m0[0] !== 1'b1)
        $display("FAIL rstp_after%0d: got sel=%b rdy=%b%b want 0 11", k, hsel_s[0], hready_m0[0], hready_m1[0]);
      else n_pass++;
      @(negedge HCLK);
    end
  endtask

  // Reference model: one parking slot per master, replayed on grant; mode 0 alternates ties, mode 1 favours M0.
  task automatic test_random();
    bit          m_pend   [2][2];
    logic [31:0] m_paddr  [2][2];
    logic        m_pwrite [2][2];
    logic [2:0]  m_psize  [2][2];
    bit          m_dvalid [2];
    int          m_downer [2];
    int          m_last   [2];
    bit          req      [2][2];
    bit          rdy      [2][2];
    int          win      [2];
    bit          rst;
    logic        e_sel;
    logic [31:0] e_addr;
    logic        e_wr;
    logic [2:0]  e_size;
    do_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m][0] = 0; m_pend[m][1] = 0;
      m_dvalid[m] = 0; m_downer[m] = 0; m_last[m] = 1;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc != 0) @(negedge HCLK);
      rst = ($urandom_range(0, 59) == 0);
      HRESET = rst;
      random_inputs();
      #1;
      for (int m = 0; m < 2; m++) begin
        for (int x = 0; x < 2; x++) begin
          rdy[m][x] = !(m_pend[m][x] || (m_dvalid[m] && m_downer[m] == x && !hreadyout_s));
          req[m][x] = m_pend[m][x] || (htrans[x][1] && rdy[m][x]);
        end
        win[m] = -1;
        if (!rst && hreadyout_s && (req[m][0] || req[m][1])) begin
          if (req[m][0] && req[m][1]) win[m] = (m == 1) ? 0 : (m_last[m] == 0 ? 1 : 0);
          else win[m] = req[m][0] ? 0 : 1;
        end
        e_sel = (win[m] >= 0);
        if (win[m] < 0) begin
          e_addr = haddr[0]; e_wr = hwrite[0]; e_size = hsize[0];
        end else if (m_pend[m][win[m]]) begin
          e_addr = m_paddr[m][win[m]]; e_wr = m_pwrite[m][win[m]]; e_size = m_psize[m][win[m]];
        end else begin
          e_addr = haddr[win[m]]; e_wr = hwrite[win[m]]; e_size = hsize[win[m]];
        end
        n_checks++;
        if (hsel_s[m] !== e_sel || htrans_s[m] !== (e_sel ? 2'b10 : 2'b00))
          $display("FAIL rand_sel m%0d c%0d: got sel=%b trans=%b want sel=%b", m, cyc, hsel_s[m], htrans_s[m], e_sel);
        else n_pass++;
        n_checks++;
        if (haddr_s[m] !== e_addr || hwrite_s[m] !== e_wr || hsize_s[m] !== e_size)
          $display("FAIL rand_addr m%0d c%0d: got %h/%b/%0d want %h/%b/%0d", m, cyc, haddr_s[m], hwrite_s[m], hsize_s[m], e_addr, e_wr, e_size);
        else n_pass++;
        n_checks++;
        if (hready_m0[m] !== rdy[m][0] || hready_m1[m] !== rdy[m][1])
          $display("FAIL rand_hready m%0d c%0d: got %b%b want %b%b", m, cyc, hready_m0[m], hready_m1[m], rdy[m][0], rdy[m][1]);
        else n_pass++;
        if (m_dvalid[m]) begin
          n_checks++;
          if (hwdata_s[m] !== hwdata[m_downer[m]])
            $display("FAIL rand_wdata m%0d c%0d: got %h want %h", m, cyc, hwdata_s[m], hwdata[m_downer[m]]);
          else n_pass++;
        end
        n_checks++;
        if (hrdata_m0[m] !== hrdata_s || hrdata_m1[m] !== hrdata_s || hready_s[m] !== hreadyout_s ||
            hresp_m0[m] !== 1'b0 || hresp_m1[m] !== 1'b0)
          $display("FAIL rand_pass m%0d c%0d: got rd=%h/%h rdys=%b resp=%b%b want rd=%h rdys=%b resp=00", m, cyc,
                   hrdata_m0[m], hrdata_m1[m], hready_s[m], hresp_m0[m], hresp_m1[m], hrdata_s, hreadyout_s);
        else n_pass++;
      end
      @(posedge HCLK);
      for (int m = 0; m < 2; m++) begin
        if (rst) begin
          m_pend[m][0] = 0; m_pend[m][1] = 0;
          m_dvalid[m] = 0; m_downer[m] = 0; m_last[m] = 1;
        end else begin
          for (int x = 0; x < 2; x++) begin
            if (win[m] == x && m_pend[m][x]) m_pend[m][x] = 0;
            else if (req[m][x] && win[m] != x && !m_pend[m][x]) begin
              m_pend[m][x] = 1; m_paddr[m][x] = haddr[x]; m_pwrite[m][x] = hwrite[x]; m_psize[m][x] = hsize[x];
            end
          end
          if (win[m] >= 0) m_last[m] = win[m];
          if (hreadyout_s) begin
            m_dvalid[m] = (win[m] >= 0);
            if (win[m] >= 0) m_downer[m] = win[m];
          end
        end
      end
    end
    @(negedge HCLK);
    HRESET = 1'b0;
    idle_masters();
  endtask

  initial begin
    HRESET = 1'b1;
    idle_masters();
    test_reset();
    test_single_write();
    test_contention();
    test_back_to_back();
    test_stall();
    test_reset_pending();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_mem_arbiter.md
AHB_MEM_ARBITER -- requirements
Module: ahb_mem_arbiter

Interface
REQ-001 SHALL have parameter PRIORITY_MODE, default 0; 0 = round-robin, 1 = fixed priority with M0 highest.
REQ-002 SHALL have ports:
- HCLK  in  1  single clock; all state updates on the rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HTRANS_M0/M1  in  2 each  master transfer type.
- HADDR_M0/M1  in  32 each  master address.
- HWRITE_M0/M1  in  1 each  master write flag.
- HSIZE_M0/M1  in  3 each  master transfer size.
- HWDATA_M0/M1  in  32 each  master write data.
- HREADY_M0/M1  out  1 each  ready back to each master.
- HRDATA_M0/M1  out  32 each  read data back to each master.
- HRESP_M0/M1  out  1 each  response to each master; tied 0 (OKAY).
- HSEL_S  out  1  memory slave select.
- HADDR_S  out  32  slave address.
- HTRANS_S  out  2  slave transfer type.
- HWRITE_S  out  1  slave write flag.
- HSIZE_S  out  3  slave transfer size.
- HWDATA_S  out  32  slave write data.
- HREADY_S  out  1  slave HREADY input.
- HREADYOUT_S  in  1  slave ready.
- HRDATA_S  in  32  slave read data.

Function
REQ-003 SHALL share one AHB-Lite memory slave between two AHB-Lite masters, M0 and M1.
REQ-004 SHALL count a master request as req_x = pend_x | (HTRANS_Mx[1] & HREADY_Mx).
REQ-005 SHALL arbitrate only in cycles where HREADYOUT_S=1. At most one grant per cycle.
REQ-006 Round-robin tie-break: the master not granted last time wins. Fixed mode: M0 wins. A lone requester always wins.
REQ-007 SHALL set last_grant on every grant.
REQ-008 A requesting master that is not granted in a cycle SHALL have HADDR/HWRITE/HSIZE captured into its pending register, and pend_x set.
REQ-009 A granted master with pend_x=1 SHALL issue from its pending register, then clear pend_x. Otherwise it issues from its live bus.
REQ-010 An issued transfer SHALL drive HSEL_S=1 and HTRANS_S=2'b10 (NONSEQ) in the same cycle. SEQ is always converted to NONSEQ.
REQ-011 With no issue: HSEL_S=0 and HTRANS_S=2'b00. HADDR_S/HWRITE_S/HSIZE_S SHALL then drive the M0 live bus.
REQ-012 On each HREADYOUT_S=1 edge: data_owner <= granted master; data_valid <= issue.
REQ-013 HWDATA_S SHALL be muxed by data_owner.
REQ-014 HRDATA_M0 and HRDATA_M1 SHALL both equal HRDATA_S.
REQ-015 HREADY_S SHALL equal HREADYOUT_S.
REQ-016 HREADY_Mx SHALL be 0 when pend_x=1, or when (data_valid & data_owner==x & HREADYOUT_S=0). Otherwise 1.
REQ-017 An uncontended transfer SHALL see zero added wait states.
REQ-018 A contended loser SHALL see exactly one added wait state per winning transfer ahead of it, plus any slave stall.
REQ-019 During a slave stall (HREADYOUT_S=0): no new issue; HADDR_S/HTRANS_S held stable; new master requests captured per REQ-008.
REQ-020 IDLE and BUSY master transfers SHALL never be forwarded or captured.
REQ-021 In fixed mode, continuous M0 requests may starve M1; this is accepted behaviour.

Reset
REQ-022 While HRESET=1 at an edge: pend_0 = pend_1 = 0, data_valid = 0, data_owner = M0, last_grant = M1 (so M0 wins the first tie).
REQ-023 After reset: HSEL_S=0, HTRANS_S=00, HREADY_M0 = HREADY_M1 = 1, HRESP = 0.
REQ-024 Reset asserted mid-transfer SHALL discard pending requests with no further slave issue. An in-flight data phase is abandoned.

Verification
REQ-025 Reset held 2 cycles with random master inputs -> HSEL_S=0, HTRANS_S=00, both HREADY_Mx=1.
REQ-026 M0 alone, word write to 0x0000_0010, data 0xDEADBEEF -> HSEL_S=1 and HADDR_S=0x10 in cycle t; HWDATA_S=0xDEADBEEF in t+1; HREADY_M0=1 throughout.
REQ-027 Cycle t after reset: M0 reads 0x20 while M1 writes 0xA5A5A5A5 to 0x30 -> expected:
- t: M0 issued, 0x20.
- t+1: M1 issued from pending, 0x30; HREADY_M1=0.
- t+2: HREADY_M1=1; HWDATA_S=0xA5A5A5A5.
REQ-028 Both masters request NONSEQ every cycle for 8 grants -> round-robin: grants alternate M0, M1, M0, ... Fixed mode: all 8 grants to M0.
REQ-029 HREADYOUT_S=0 for 3 cycles during an M0 data phase while M1 requests 0x40 -> HREADY_M0=0 for 3 cycles; M1 pending; 0x40 issued in the first HREADYOUT_S=1 cycle; slave address stable while stalled.
REQ-030 HRESET pulsed while pend_1=1 -> pend_1 cleared; no 0x40 issue after reset; HREADY_M1=1 the cycle after.
